// File: rtl/multitap_gen.sv
// Parametrised Mega Drive multitap: per-pad type IDs, packed data walk over present
// pads, and an idle timeout that rearms the frame.
module multitap_gen #(
   parameter int NUM_PADS       = 4,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    port_sel,
   input  logic [2*NUM_PADS-1:0]   pad_type,
   input  logic [12*NUM_PADS-1:0]  buttons,
   output logic [6:0]              port1_out,
   input  logic [6:0]              port1_in,
   input  logic [6:0]              port1_dir,
   output logic [6:0]              port2_out,
   input  logic [6:0]              port2_in,
   input  logic [6:0]              port2_dir,
   output logic                    busy
);

   localparam int HDR_END = 4 + NUM_PADS;
   localparam int PW      = $clog2(NUM_PADS + 1);
   localparam int TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [1:0]            hs, state;
   logic [5:0]            cnt, cnt_nxt;
   logic [6:0]            out_q;
   logic [2*NUM_PADS-1:0] type_q;
   logic [PW-1:0]         ptr, ptr_first, ptr_next;
   logic [1:0]            nib_idx;
   logic [TW-1:0]         timer;
   logic                  edge_det, th_rise, timeout, last_nib;
   logic [3:0]            nib;
   logic [1:0]            slot_type;
   int                    ptr_i;

   function automatic logic [5:0] sat_inc6(input logic [5:0] v);
      return (v == 6'd63) ? v : v + 6'd1;
   endfunction

   always_comb begin
      hs       = port_sel ? (port2_in[6:5] | port2_dir[6:5]) : (port1_in[6:5] | port1_dir[6:5]);
      edge_det = (hs != state);
      th_rise  = !state[1] && hs[1];
      cnt_nxt  = th_rise ? 6'd0 : sat_inc6(cnt);
      timeout  = (TIMEOUT_CYCLES != 0) && (timer == TW'(TIMEOUT_CYCLES - 1));
   end

   // Present-slot search: absent slots have type bit 1 set
   always_comb begin
      ptr_first = PW'(NUM_PADS);
      ptr_next  = PW'(NUM_PADS);
      for (int j = NUM_PADS - 1; j >= 0; j--) begin
         if (!type_q[2*j+1]) begin
            ptr_first = PW'(j);
            if (PW'(j) > ptr) ptr_next = PW'(j);
         end
      end
   end

   always_comb begin
      ptr_i     = (ptr < PW'(NUM_PADS)) ? int'(ptr) : 0;
      last_nib  = type_q[2*ptr_i] ? (nib_idx == 2'd2) : (nib_idx == 2'd1);
      slot_type = 2'b11;
      nib       = 4'hF;
      if (cnt == 6'd0)
         nib = 4'b0011;
      else if (cnt == 6'd1)
         nib = 4'b1111;
      else if (cnt < 6'd4)
         nib = 4'b0000;
      else if (int'(cnt) < HDR_END) begin
         slot_type = type_q[2*(int'(cnt)-4) +: 2];
         nib       = slot_type[1] ? 4'hF : {3'b000, slot_type[0]};
      end else if (ptr != PW'(NUM_PADS))
         nib = ~buttons[12*ptr_i + 4*int'(nib_idx) +: 4];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= 2'b11;
         cnt     <= 6'd0;
         out_q   <= 7'b1100011;
         ptr     <= '0;
         nib_idx <= 2'd0;
         timer   <= '0;
      end else begin
         out_q <= {state, state[0], nib};
         if (int'(cnt) < HDR_END) begin
            ptr     <= ptr_first;
            nib_idx <= 2'd0;
         end
         if (edge_det) begin
            state <= hs;
            cnt   <= cnt_nxt;
            timer <= '0;
            if (int'(cnt) >= HDR_END && !th_rise && ptr != PW'(NUM_PADS)) begin
               if (last_nib) begin
                  ptr     <= ptr_next;
                  nib_idx <= 2'd0;
               end else
                  nib_idx <= nib_idx + 2'd1;
            end
         end else if (timeout) begin
            cnt     <= 6'd0;
            ptr     <= '0;
            nib_idx <= 2'd0;
            timer   <= '0;
         end else
            timer <= timer + TW'(1);
      end
   end

   // Pad types are frozen for the whole frame at its first handshake edge
   always_ff @(posedge clk) begin
      if (!reset && edge_det && !th_rise && cnt == 6'd0)
         type_q <= pad_type;
   end

   assign port1_out = (~port1_dir & port1_in) | (port1_dir & out_q);
   assign port2_out = (~port2_dir & port2_in) | (port2_dir & out_q);
   assign busy      = (cnt != 6'd0);

endmodule

// File: tb/tb_multitap_gen.sv
// Self-checking bench for multitap_gen: frames compared against a nibble-list model
// built from the pad types and buttons.
module tb_multitap_gen;

   localparam int NP = 4;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            reset, port_sel;
   logic [2*NP-1:0] pad_type;
   logic [12*NP-1:0] buttons;
   logic [6:0]      p1_out, p1_in, p1_dir, p2_out, p2_in, p2_dir;
   logic            busy;

   int              n_checks = 0;
   int              n_fail   = 0;
   logic            tr_cur;
   logic [3:0]      exp_q[$];

   multitap_gen #(.NUM_PADS(NP), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .port_sel(port_sel), .pad_type(pad_type), .buttons(buttons),
      .port1_out(p1_out), .port1_in(p1_in), .port1_dir(p1_dir),
      .port2_out(p2_out), .port2_in(p2_in), .port2_dir(p2_dir), .busy(busy));

   always #5 clk = ~clk;

   // Expected frame: header, type IDs, then each present pad's nibbles, then idle 1111
   task automatic build_model(input logic [2*NP-1:0] t, input logic [12*NP-1:0] b);
      exp_q = {4'hF, 4'h0, 4'h0};
      for (int i = 0; i < NP; i++)
         exp_q.push_back(t[2*i+1] ? 4'hF : {3'b000, t[2*i]});
      for (int i = 0; i < NP; i++)
         if (!t[2*i+1])
            for (int k = 0; k < (t[2*i] ? 3 : 2); k++)
               exp_q.push_back(~b[12*i+4*k +: 4]);
      while (exp_q.size() < 24) exp_q.push_back(4'hF);
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_hs(input logic th, input logic tr);
      if (port_sel) p2_in[6:5] = {th, tr};
      else          p1_in[6:5] = {th, tr};
      tr_cur = tr;
      wait_clks(3);
   endtask

   function automatic logic [3:0] nib_obs();
      return port_sel ? p2_out[3:0] : p1_out[3:0];
   endfunction

   task automatic start_frame();
      drive_hs(1'b1, 1'b1);
      drive_hs(1'b0, 1'b1);
   endtask

   task automatic rand_buttons();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      buttons = r[12*NP-1:0];
   endtask

   task automatic test_reset();
      reset = 1'b1; port_sel = 1'b0; pad_type = '0; buttons = '0;
      p1_dir = 7'h7F; p1_in = 7'h00; p2_dir = 7'h00; p2_in = 7'b1100000;
      wait_clks(2);
      n_checks++;
      if (p1_out !== 7'b1100011) begin n_fail++; $display("FAIL reset_out: got %b want 1100011", p1_out); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      p1_dir = 7'h0F; p1_in = 7'b1100000; reset = 1'b0; tr_cur = 1'b1;
      wait_clks(3);
      n_checks++;
      if (nib_obs() !== 4'b0011) begin n_fail++; $display("FAIL idle_nib: got %b want 0011", nib_obs()); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
      n_checks++;
      if (p1_out[6:4] !== 3'b110) begin n_fail++; $display("FAIL idle_passthru: got %b want 110", p1_out[6:4]); end
   endtask

   task automatic test_frame_fixed();
      pad_type = {2'd0, 2'd2, 2'd1, 2'd0};
      rand_buttons();
      build_model(pad_type, buttons);
      start_frame();
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL frame_busy: got %b want 1", busy); end
      for (int e = 0; e < 22; e++) begin
         if (e > 0) drive_hs(1'b0, ~tr_cur);
         n_checks++;
         if (nib_obs() !== exp_q[e])
            begin n_fail++; $display("FAIL fixed_nib[%0d]: got %b want %b", e, nib_obs(), exp_q[e]); end
      end
   endtask

   task automatic test_mode_c();
      logic [3:0] want[3];
      want = '{4'b1111, 4'b1110, 4'b0111};
      pad_type = {2'd0, 2'd2, 2'd1, 2'd0};
      rand_buttons();
      buttons[23:12] = 12'h810;
      start_frame();
      for (int e = 0; e < 12; e++) begin
         if (e > 0) drive_hs(1'b0, ~tr_cur);
         if (e >= 9) begin
            n_checks++;
            if (nib_obs() !== want[e-9])
               begin n_fail++; $display("FAIL mode_c[%0d]: got %b want %b", e-9, nib_obs(), want[e-9]); end
         end
      end
   endtask

   task automatic test_random_frames();
      for (int it = 0; it < 5; it++) begin
         pad_type = 8'($urandom());
         rand_buttons();
         build_model(pad_type, buttons);
         start_frame();
         for (int e = 0; e < 22; e++) begin
            if (e > 0) drive_hs(1'b0, ~tr_cur);
            if (e == 1) pad_type = 8'($urandom());
            n_checks++;
            if (nib_obs() !== exp_q[e])
               begin n_fail++; $display("FAIL rand%0d_nib[%0d]: got %b want %b", it, e, nib_obs(), exp_q[e]); end
         end
      end
   endtask

   task automatic test_timeout();
      pad_type = 8'($urandom());
      rand_buttons();
      build_model(pad_type, buttons);
      start_frame();
      for (int e = 0; e < 10; e++) begin
         if (e > 0) drive_hs(1'b0, ~tr_cur);
         n_checks++;
         if (nib_obs() !== exp_q[e])
            begin n_fail++; $display("FAIL to_nib[%0d]: got %b want %b", e, nib_obs(), exp_q[e]); end
      end
      wait_clks(TO + 8);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL to_busy: got %b want 0", busy); end
      n_checks++;
      if (nib_obs() !== 4'b0011) begin n_fail++; $display("FAIL to_idle_nib: got %b want 0011", nib_obs()); end
      drive_hs(1'b1, tr_cur);
      n_checks++;
      if (nib_obs() !== 4'b0011) begin n_fail++; $display("FAIL to_rise_nib: got %b want 0011", nib_obs()); end
      drive_hs(1'b0, tr_cur);
      n_checks++;
      if (nib_obs() !== 4'b1111) begin n_fail++; $display("FAIL to_rearm_nib: got %b want 1111", nib_obs()); end
   endtask

   task automatic test_th_rise();
      pad_type = {2'd0, 2'd2, 2'd1, 2'd0};
      rand_buttons();
      start_frame();
      for (int e = 1; e < 10; e++) drive_hs(1'b0, ~tr_cur);
      drive_hs(1'b1, tr_cur);
      n_checks++;
      if (nib_obs() !== 4'b0011) begin n_fail++; $display("FAIL threrise_nib: got %b want 0011", nib_obs()); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL threrise_busy: got %b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      pad_type = {2'd0, 2'd2, 2'd1, 2'd0};
      start_frame();
      for (int e = 1; e < 10; e++) drive_hs(1'b0, ~tr_cur);
      reset = 1'b1; p1_dir = 7'h7F;
      @(posedge clk); #1;
      n_checks++;
      if (p1_out !== 7'b1100011) begin n_fail++; $display("FAIL midreset_out: got %b want 1100011", p1_out); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
      reset = 1'b0; p1_dir = 7'h0F; p1_in = 7'b1100000; tr_cur = 1'b1;
      wait_clks(3);
      n_checks++;
      if (nib_obs() !== 4'b0011) begin n_fail++; $display("FAIL midreset_idle: got %b want 0011", nib_obs()); end
   endtask

   task automatic test_port2();
      p2_dir = 7'h0F; p2_in = 7'b1100000;
      wait_clks(2);
      port_sel = 1'b1;
      wait_clks(2);
      p1_dir = 7'h00;
      pad_type = 8'($urandom());
      rand_buttons();
      build_model(pad_type, buttons);
      start_frame();
      for (int e = 0; e < 20; e++) begin
         if (e > 0) drive_hs(1'b0, ~tr_cur);
         n_checks++;
         if (p2_out[3:0] !== exp_q[e])
            begin n_fail++; $display("FAIL p2_nib[%0d]: got %b want %b", e, p2_out[3:0], exp_q[e]); end
         n_checks++;
         if (p1_out !== p1_in)
            begin n_fail++; $display("FAIL p1_passthru[%0d]: got %b want %b", e, p1_out, p1_in); end
         p1_in = 7'($urandom());
      end
   endtask

   initial begin
      test_reset();
      test_frame_fixed();
      test_mode_c();
      test_random_frames();
      test_timeout();
      test_th_rise();
      test_reset_mid();
      test_port2();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
